// File: rtl/idecode_pkg.sv
// Shared bexkat1 decode definitions: instruction type codes, field positions and
// the decoded-field struct used by decode and execute.
package idecode_pkg;

  localparam int          REGS     = 16;
  localparam int          AW       = $clog2(REGS);
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'hfffffffc;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 28;
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 24;
  localparam int RA_MSB   = 23;
  localparam int RA_LSB   = 20;
  localparam int RB_MSB   = 19;
  localparam int RB_LSB   = 16;
  localparam int RC_MSB   = 15;
  localparam int RC_LSB   = 12;
  localparam int SIMM_MSB = 15;
  localparam int SIMM_LSB = 1;
  localparam int LONG_BIT = 0;

  typedef enum logic [3:0] {
    T_INH    = 4'h0,
    T_PUSH   = 4'h1,
    T_POP    = 4'h2,
    T_CMP    = 4'h3,
    T_MOV    = 4'h4,
    T_INTU   = 4'h5,
    T_INT    = 4'h6,
    T_FPU    = 4'h7,
    T_FP     = 4'h8,
    T_ALU    = 4'h9,
    T_LOAD   = 4'ha,
    T_STORE  = 4'hb,
    T_BRANCH = 4'hc,
    T_JUMP   = 4'hd,
    T_LDI    = 4'he,
    T_HALT   = 4'hf
  } itype_t;

  typedef struct packed {
    itype_t      itype;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        is_long;
    logic [31:0] imm;
  } fields_t;

  function automatic fields_t decode_fields(input logic [63:0] ir);
    fields_t f;
    f.itype   = itype_t'(ir[TYPE_MSB:TYPE_LSB]);
    f.op      = ir[OP_MSB:OP_LSB];
    f.ra      = ir[RA_MSB:RA_LSB];
    f.rb      = ir[RB_MSB:RB_LSB];
    f.rc      = ir[RC_MSB:RC_LSB];
    f.is_long = ir[LONG_BIT];
    f.imm     = ir[LONG_BIT] ? ir[63:32] : {{17{ir[SIMM_MSB]}}, ir[SIMM_MSB:SIMM_LSB]};
    return f;
  endfunction

endpackage

// File: rtl/idecode_if.sv
// Signal bundle between fetch/writeback (master side) and the decode stage (slave side).
interface idecode_if;
  // Flow control: ir_i/pc_i are taken at a clock edge only while stall_o is low;
  // while stall_o is high fetch must hold ir_i/pc_i unchanged. flush_i discards
  // whatever decode would have loaded and is not gated by stall_o.
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  logic        stall_i;
  logic        flush_i;
  logic        wb_we_i;
  logic [3:0]  wb_reg_i;
  logic [31:0] wb_dat_i;
  logic        stall_o;
  logic        halt_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic [31:0] ra_o;
  logic [31:0] rb_o;
  logic [31:0] rc_o;
  logic [31:0] imm_o;

  modport master (
    output ir_i, pc_i, stall_i, flush_i, wb_we_i, wb_reg_i, wb_dat_i,
    input  stall_o, halt_o, ir_o, pc_o, ra_o, rb_o, rc_o, imm_o
  );

  modport slave (
    input  ir_i, pc_i, stall_i, flush_i, wb_we_i, wb_reg_i, wb_dat_i,
    output stall_o, halt_o, ir_o, pc_o, ra_o, rb_o, rc_o, imm_o
  );
endinterface

// File: rtl/idecode_registerfile.sv
// General register file: three combinational read ports with write-through
// bypass, one write port, asynchronous clear.
module registerfile #(
  parameter int REGS = 16,
  parameter int DW   = 32,
  parameter int AW   = $clog2(REGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic [AW-1:0] raddr_c,
  output logic [DW-1:0] rdat_a,
  output logic [DW-1:0] rdat_b,
  output logic [DW-1:0] rdat_c
);

  logic [DW-1:0] regs [REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdat;
    end
  end

  // Bypass lets decode see the value writeback commits at this same edge.
  assign rdat_a = (we && waddr == raddr_a) ? wdat : regs[raddr_a];
  assign rdat_b = (we && waddr == raddr_b) ? wdat : regs[raddr_b];
  assign rdat_c = (we && waddr == raddr_c) ? wdat : regs[raddr_c];

endmodule

// File: rtl/idecode.sv
// bexkat1 decode stage: field split, operand read, immediate forming,
// load-use hazard detection and the ID/EX pipeline register.
module idecode
  import idecode_pkg::*;
#(
  parameter int          REGS     = idecode_pkg::REGS,
  parameter logic [31:0] RESET_PC = idecode_pkg::RESET_PC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  idecode_if.slave   bus
);

  itype_t      in_type;
  itype_t      ld_type;
  logic [3:0]  in_ra, in_rb, in_rc, ld_ra;
  logic [31:0] imm_next;
  logic [31:0] rdat_a, rdat_b, rdat_c;
  logic        hazard;

  logic [63:0] ir_q;
  logic [31:0] pc_q, ra_q, rb_q, rc_q, imm_q;
  logic        halt_q;

  assign in_type  = itype_t'(bus.ir_i[TYPE_MSB:TYPE_LSB]);
  assign in_ra    = bus.ir_i[RA_MSB:RA_LSB];
  assign in_rb    = bus.ir_i[RB_MSB:RB_LSB];
  assign in_rc    = bus.ir_i[RC_MSB:RC_LSB];
  assign ld_type  = itype_t'(ir_q[TYPE_MSB:TYPE_LSB]);
  assign ld_ra    = ir_q[RA_MSB:RA_LSB];
  assign imm_next = bus.ir_i[LONG_BIT] ? bus.ir_i[63:32]
                                       : {{17{bus.ir_i[SIMM_MSB]}}, bus.ir_i[SIMM_MSB:SIMM_LSB]};

  registerfile #(.REGS(REGS), .DW(32)) u_regs (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we      (bus.wb_we_i),
    .waddr   (bus.wb_reg_i),
    .wdat    (bus.wb_dat_i),
    .raddr_a (in_ra),
    .raddr_b (in_rb),
    .raddr_c (in_rc),
    .rdat_a  (rdat_a),
    .rdat_b  (rdat_b),
    .rdat_c  (rdat_c)
  );

  // A load in ID/EX whose destination is a source of the incoming instruction
  // must not forward yet; ra counts as a source only for stores.
  always_comb begin
    hazard = 1'b0;
    if (ir_q != '0 && ld_type == T_LOAD && bus.ir_i != '0) begin
      hazard = (ld_ra == in_rb) || (ld_ra == in_rc) ||
               (in_type == T_STORE && ld_ra == in_ra);
    end
  end

  // flush_i deliberately stays out of stall_o so fetch handles it on its own path.
  assign bus.stall_o = hazard | bus.stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_q   <= '0;
      pc_q   <= RESET_PC;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      imm_q  <= '0;
      halt_q <= 1'b0;
    end else if (bus.flush_i) begin
      ir_q  <= '0;
      imm_q <= '0;
    end else if (bus.stall_i) begin
      ir_q <= ir_q;
    end else if (hazard) begin
      ir_q <= '0;
    end else begin
      ir_q  <= bus.ir_i;
      pc_q  <= bus.pc_i;
      ra_q  <= rdat_a;
      rb_q  <= rdat_b;
      rc_q  <= rdat_c;
      imm_q <= imm_next;
      if (in_type == T_HALT) halt_q <= 1'b1;
    end
  end

  assign bus.ir_o   = ir_q;
  assign bus.pc_o   = pc_q;
  assign bus.ra_o   = ra_q;
  assign bus.rb_o   = rb_q;
  assign bus.rc_o   = rc_q;
  assign bus.imm_o  = imm_q;
  assign bus.halt_o = halt_q;

endmodule
